// File: rtl/pointwise_conv_engine.sv
// ---------------------------------------------------------------------------
// pointwise_conv_engine
//
// 1x1 convolution engine. Each accepted input beat carries one activation
// pixel. The pixel goes to LANES multiply-accumulate lanes, and each lane has
// its own weight. After CHIN beats, every lane's accumulator is requantised:
// round half up, arithmetic shift by FRAC_BITS, saturate to WIDTH bits, and
// optionally apply ReLU. The LANES results are then offered on a valid/ready
// output port.
//
// Ports
//   clk        in   single clock, all logic on posedge
//   rst        in   synchronous, active-high reset
//   start      in   begin one output pixel (honoured only in IDLE)
//   ifm_valid  in   input beat valid
//   ifm_ready  out  engine accepts a beat (high exactly in ACCUM)
//   ifm_pix    in   signed activation, broadcast to all lanes
//   ker        in   signed weights, lane k = ker[k*WIDTH +: WIDTH]
//   ofm_valid  out  ofm holds a complete result
//   ofm_ready  in   consumer takes ofm
//   ofm        out  requantised results, lane k = ofm[k*WIDTH +: WIDTH]
//   busy       out  engine not idle
//   done       out  one-cycle pulse on the ofm handshake cycle
//
// Pipeline for the final beat, accepted on edge E0:
//   E0: pixel and weights captured
//   E1: lane products registered
//   E2: products added into the accumulators
//   E3: results and ofm_valid registered
// ---------------------------------------------------------------------------
module pointwise_conv_engine #(
    parameter int LANES     = 256,
    parameter int WIDTH     = 16,
    parameter int CHIN      = 736,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 42,
    parameter int RELU_EN   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     ifm_valid,
    output logic                     ifm_ready,
    input  logic [WIDTH-1:0]         ifm_pix,
    input  logic [LANES*WIDTH-1:0]   ker,
    output logic                     ofm_valid,
    input  logic                     ofm_ready,
    output logic [LANES*WIDTH-1:0]   ofm,
    output logic                     busy,
    output logic                     done
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (CHIN > 1) ? $clog2(CHIN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(CHIN - 1);

    // The rounding and saturation arithmetic is done one bit wider than the
    // accumulator. This keeps the rounding add from overflowing.
    localparam logic signed [ACC_W:0] ROUND_ADD = (ACC_W+1)'(1) << (FRAC_BITS - 1);
    localparam logic signed [ACC_W:0] SAT_MAX   = {{(ACC_W-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN   = {{(ACC_W-WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

    // Elaboration-time parameter sanity checks.
    if (CHIN < 1) begin : g_chk_chin
        $error("pointwise_conv_engine: CHIN must be >= 1");
    end
    if (FRAC_BITS < 1 || FRAC_BITS > ACC_W) begin : g_chk_frac
        $error("pointwise_conv_engine: FRAC_BITS out of range");
    end
    if (ACC_W < 2*WIDTH + $clog2(CHIN)) begin : g_chk_accw
        $error("pointwise_conv_engine: ACC_W too narrow, accumulator could overflow");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_DRAIN  = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    state_t                    state_reg, state_next;
    logic                      drain_reg;      // set during the second DRAIN cycle
    logic [CNT_W-1:0]          beat_cnt_reg;
    logic                      s0_vld_reg;     // captured beat waiting for multiply
    logic                      s1_vld_reg;     // product waiting for accumulate
    logic signed [WIDTH-1:0]   pix_reg;
    logic                      ofm_valid_reg;

    logic                      beat;
    logic                      last_beat;
    logic                      acc_clr;
    logic                      ofm_load;
    logic                      handshake;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        ifm_ready  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_ACCUM;
            end
            S_ACCUM: begin
                ifm_ready = 1'b1;
                if (ifm_valid && (beat_cnt_reg == LAST_BEAT)) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_reg) state_next = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (ofm_valid_reg && ofm_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign beat      = ifm_valid && ifm_ready;
    assign last_beat = (beat_cnt_reg == LAST_BEAT);
    assign acc_clr   = (state_reg == S_IDLE) && start;
    // Results become visible one cycle after OUTPUT is entered. By then the
    // last accumulate (E2) has landed in the accumulators.
    assign ofm_load  = (state_reg == S_OUTPUT) && !ofm_valid_reg;
    assign handshake = (state_reg == S_OUTPUT) && ofm_valid_reg && ofm_ready;

    assign busy      = (state_reg != S_IDLE);
    assign done      = handshake;
    assign ofm_valid = ofm_valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            drain_reg     <= 1'b0;
            beat_cnt_reg  <= '0;
            s0_vld_reg    <= 1'b0;
            s1_vld_reg    <= 1'b0;
            pix_reg       <= '0;
            ofm_valid_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            drain_reg  <= (state_reg == S_DRAIN) && !drain_reg;

            if (acc_clr) begin
                beat_cnt_reg <= '0;
            end else if (beat) begin
                beat_cnt_reg <= last_beat ? '0 : beat_cnt_reg + CNT_W'(1);
            end

            s0_vld_reg <= beat;
            s1_vld_reg <= s0_vld_reg;
            if (beat) pix_reg <= ifm_pix;

            if (ofm_load) begin
                ofm_valid_reg <= 1'b1;
            end else if (handshake) begin
                ofm_valid_reg <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-lane MAC and requantisation
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [WIDTH-1:0] ker_lane_reg;
            logic signed [PW-1:0]    prod_reg;
            logic signed [ACC_W-1:0] acc_reg;
            logic [WIDTH-1:0]        ofm_lane_reg;
            logic signed [ACC_W:0]   rnd_sum;
            logic signed [ACC_W:0]   shifted;
            logic signed [WIDTH-1:0] q_next;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ker_lane_reg <= '0;
                    prod_reg     <= '0;
                    acc_reg      <= '0;
                    ofm_lane_reg <= '0;
                end else begin
                    if (beat) ker_lane_reg <= ker[gi*WIDTH +: WIDTH];
                    // Both operands are signed and sign-extended to PW
                    // bits, so the low PW bits are the exact product.
                    if (s0_vld_reg) prod_reg <= PW'(pix_reg) * PW'(ker_lane_reg);
                    if (acc_clr) begin
                        acc_reg <= '0;
                    end else if (s1_vld_reg) begin
                        acc_reg <= acc_reg + ACC_W'(prod_reg);
                    end
                    if (ofm_load) ofm_lane_reg <= q_next;
                end
            end

            always_comb begin
                rnd_sum = (ACC_W+1)'(acc_reg) + ROUND_ADD;
                shifted = rnd_sum >>> FRAC_BITS;
                if (shifted > SAT_MAX) begin
                    q_next = SAT_MAX[WIDTH-1:0];
                end else if (shifted < SAT_MIN) begin
                    q_next = SAT_MIN[WIDTH-1:0];
                end else begin
                    q_next = shifted[WIDTH-1:0];
                end
                if ((RELU_EN != 0) && q_next[WIDTH-1]) q_next = '0;
            end

            assign ofm[gi*WIDTH +: WIDTH] = ofm_lane_reg;
        end
    endgenerate

endmodule

// File: tb/tb_pointwise_conv_engine.sv
// ---------------------------------------------------------------------------
// tb_pointwise_conv_engine
//
// Testbench for pointwise_conv_engine (LANES=4, CHIN=3, WIDTH=16,
// FRAC_BITS=8). Two engines share all inputs: one is built with ReLU off and
// one with ReLU on. A table of spec-derived vectors is run first. Hand-written
// reset and start-pulse sequences follow. Randomised pixels are then checked
// against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_pointwise_conv_engine;

    localparam int LANES = 4;
    localparam int WIDTH = 16;
    localparam int CHIN  = 3;
    localparam int FRAC  = 8;
    localparam int ACC_W = 42;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst, start, ifm_valid, ofm_ready;
    logic [WIDTH-1:0]       ifm_pix;
    logic [LANES*WIDTH-1:0] ker;
    logic                   ifm_ready0, ofm_valid0, busy0, done0;
    logic                   ifm_ready1, ofm_valid1, busy1, done1;
    logic [LANES*WIDTH-1:0] ofm0, ofm1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0]       cur_pix [CHIN];
    logic [LANES*WIDTH-1:0] cur_ker [CHIN];
    logic [63:0]            got0, got1;

    pointwise_conv_engine #(
        .LANES(LANES), .WIDTH(WIDTH), .CHIN(CHIN),
        .FRAC_BITS(FRAC), .ACC_W(ACC_W), .RELU_EN(0)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start),
        .ifm_valid(ifm_valid), .ifm_ready(ifm_ready0), .ifm_pix(ifm_pix), .ker(ker),
        .ofm_valid(ofm_valid0), .ofm_ready(ofm_ready), .ofm(ofm0),
        .busy(busy0), .done(done0)
    );

    pointwise_conv_engine #(
        .LANES(LANES), .WIDTH(WIDTH), .CHIN(CHIN),
        .FRAC_BITS(FRAC), .ACC_W(ACC_W), .RELU_EN(1)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start),
        .ifm_valid(ifm_valid), .ifm_ready(ifm_ready1), .ifm_pix(ifm_pix), .ker(ker),
        .ofm_valid(ofm_valid1), .ofm_ready(ofm_ready), .ofm(ofm1),
        .busy(busy1), .done(done1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: sum of products in plain integers, then round/shift/clamp.
    function automatic logic [63:0] model(input bit relu);
        logic [63:0]       res;
        longint            acc;
        longint            r;
        logic signed [15:0] p;
        logic signed [15:0] w;
        res = '0;
        for (int k = 0; k < LANES; k++) begin
            acc = 0;
            for (int b = 0; b < CHIN; b++) begin
                p = cur_pix[b];
                w = cur_ker[b][k*WIDTH +: WIDTH];
                acc += longint'(p) * longint'(w);
            end
            r = (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
            if (r > 32767)  r = 32767;
            if (r < -32768) r = -32768;
            if (relu && r < 0) r = 0;
            res[k*WIDTH +: WIDTH] = r[15:0];
        end
        return res;
    endfunction

    function automatic logic [15:0] rnd_val();
        logic signed [15:0] x;
        x = 16'($urandom);
        return 16'(x >>> $urandom_range(0, 12));
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_ifm_ready"}, 64'(ifm_ready0), 64'd0);
        check({tag, "_ofm_valid"}, 64'(ofm_valid0 | ofm_valid1), 64'd0);
        check({tag, "_busy"},      64'(busy0 | busy1), 64'd0);
        check({tag, "_done"},      64'(done0 | done1), 64'd0);
    endtask

    // Runs one output pixel using cur_pix/cur_ker and leaves the results in
    // got0/got1. The bench can insert ifm_valid gaps, stall ofm_ready, and
    // toggle start in states where it must be ignored.
    task automatic run_pixel(input string tag, input int gap_pct, input int hold, input bit poke);
        int          beats, guard, lat, extra;
        logic        rdy;
        logic [63:0] snap0, snap1;
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_ready_accum"}, 64'(ifm_ready0), 64'd1);
        check({tag, "_busy_accum"},  64'(busy0), 64'd1);

        beats = 0;
        guard = 0;
        while (beats < CHIN && guard < 200) begin
            ifm_valid = ($urandom_range(0, 99) >= gap_pct);
            ifm_pix   = cur_pix[beats];
            ker       = cur_ker[beats];
            if (poke) start = 1'($urandom_range(0, 1));
            rdy = ifm_ready0;
            step();
            if (ifm_valid && rdy) beats++;
            guard++;
        end
        check({tag, "_beats_taken"}, 64'(beats), 64'(CHIN));

        // Keep offering junk. The engine must not take any more beats.
        ifm_valid = 1'b1;
        ifm_pix   = rnd_val();
        ker       = {rnd_val(), rnd_val(), rnd_val(), rnd_val()};
        check({tag, "_ready_drop"}, 64'(ifm_ready0), 64'd0);
        lat   = 0;
        extra = 0;
        while (!ofm_valid0 && lat < 20) begin
            if (ifm_valid && ifm_ready0) extra++;
            if (poke) start = 1'b1;
            step();
            lat++;
        end
        check({tag, "_latency"},     64'(lat), 64'd3);
        check({tag, "_extra_beats"}, 64'(extra), 64'd0);
        check({tag, "_valid1"},      64'(ofm_valid1), 64'd1);

        snap0 = ofm0;
        snap1 = ofm1;
        ofm_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            if (poke) start = ~start;
            step();
            check({tag, "_hold_ofm0"},  ofm0, snap0);
            check({tag, "_hold_ofm1"},  ofm1, snap1);
            check({tag, "_hold_valid"}, 64'(ofm_valid0), 64'd1);
            check({tag, "_hold_ready"}, 64'(ifm_ready0), 64'd0);
            check({tag, "_hold_done"},  64'(done0), 64'd0);
        end

        // Release the output. start is also raised in the done cycle.
        ofm_ready = 1'b1;
        ifm_valid = 1'b0;
        if (poke) start = 1'b1;
        #1;
        check({tag, "_done0"}, 64'(done0), 64'd1);
        check({tag, "_done1"}, 64'(done1), 64'd1);
        got0 = ofm0;
        got1 = ofm1;
        step();
        ofm_ready = 1'b0;
        start     = 1'b0;
        check_idle({tag, "_after"});
        step();
        check({tag, "_stay_idle"}, 64'(busy0), 64'd0);
    endtask

    typedef struct {
        logic [15:0] pix;
        logic [63:0] ker;
        int          gap;
        int          hold;
        bit          poke;
        logic [63:0] exp0;
        logic [63:0] exp1;
    } vec_t;

    localparam int NV = 7;
    vec_t  tbl      [NV];
    string tbl_name [NV];

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        ifm_valid = 1'b0;
        ofm_ready = 1'b0;
        ifm_pix   = '0;
        ker       = '0;

        tbl_name[0] = "basic";
        tbl[0] = '{16'h0100, 64'h0400_0300_0200_0100, 0, 0, 1'b0,
                   64'h0C00_0900_0600_0300, 64'h0C00_0900_0600_0300};
        tbl_name[1] = "sat_pos";
        tbl[1] = '{16'h7FFF, 64'h7FFF_7FFF_7FFF_7FFF, 0, 0, 1'b0,
                   64'h7FFF_7FFF_7FFF_7FFF, 64'h7FFF_7FFF_7FFF_7FFF};
        tbl_name[2] = "sat_neg";
        tbl[2] = '{16'h7FFF, 64'h8001_8001_8001_8001, 0, 0, 1'b0,
                   64'h8000_8000_8000_8000, 64'h0};
        tbl_name[3] = "round_pos";
        tbl[3] = '{16'h0001, 64'h0080_0080_0080_0080, 0, 0, 1'b0,
                   64'h0002_0002_0002_0002, 64'h0002_0002_0002_0002};
        tbl_name[4] = "round_neg";
        tbl[4] = '{16'hFFFF, 64'h0080_0080_0080_0080, 0, 0, 1'b0,
                   64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        tbl_name[5] = "flow";
        tbl[5] = '{16'h0100, 64'h0400_0300_0200_0100, 50, 5, 1'b0,
                   64'h0C00_0900_0600_0300, 64'h0C00_0900_0600_0300};
        tbl_name[6] = "start_poke";
        tbl[6] = '{16'h0100, 64'h0400_0300_0200_0100, 30, 3, 1'b1,
                   64'h0C00_0900_0600_0300, 64'h0C00_0900_0600_0300};

        step();
        step();
        rst = 1'b0;
        check_idle("reset");
        check("reset_ofm", ofm0 | ofm1, 64'd0);

        for (int v = 0; v < NV; v++) begin
            for (int b = 0; b < CHIN; b++) begin
                cur_pix[b] = tbl[v].pix;
                cur_ker[b] = tbl[v].ker;
            end
            run_pixel(tbl_name[v], tbl[v].gap, tbl[v].hold, tbl[v].poke);
            check({tbl_name[v], "_ofm_relu0"}, got0, tbl[v].exp0);
            check({tbl_name[v], "_ofm_relu1"}, got1, tbl[v].exp1);
            $display("vec %-10s ofm0=%h ofm1=%h", tbl_name[v], got0, got1);
        end

        // Reset in the middle of ACCUM after two junk beats, then rerun the
        // basic case. Nothing from the abandoned pixel may leak through.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            ifm_valid = 1'b1;
            ifm_pix   = 16'h1234;
            ker       = 64'h0777_0555_0333_0111;
            step();
        end
        ifm_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("midreset");
        check("midreset_ofm", ofm0 | ofm1, 64'd0);
        for (int b = 0; b < CHIN; b++) begin
            cur_pix[b] = 16'h0100;
            cur_ker[b] = 64'h0400_0300_0200_0100;
        end
        run_pixel("post_reset", 0, 1, 1'b0);
        check("post_reset_ofm0", got0, 64'h0C00_0900_0600_0300);
        check("post_reset_ofm1", got1, 64'h0C00_0900_0600_0300);
        $display("seq post_reset  ofm0=%h ofm1=%h", got0, got1);

        // Randomised pixels checked against the reference model.
        for (int t = 0; t < 25; t++) begin
            for (int b = 0; b < CHIN; b++) begin
                cur_pix[b] = rnd_val();
                cur_ker[b] = {rnd_val(), rnd_val(), rnd_val(), rnd_val()};
            end
            run_pixel("rand", $urandom_range(0, 60), $urandom_range(0, 4),
                      1'($urandom_range(0, 1)));
            check("rand_ofm_relu0", got0, model(1'b0));
            check("rand_ofm_relu1", got1, model(1'b1));
            $display("rand %0d ofm0=%h ofm1=%h", t, got0, got1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
